// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes, error codes and decode helpers for the RV32I load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
    function automatic logic f3_illegal(input logic store, input logic [2:0] funct3);
        if (store) return funct3[2] || (funct3 == 3'b011);
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/mask shifted into a two-beat line, load bytes
// extracted from that line and sign/zero-extended.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [2:0]                  funct3,
    input  logic [31:0]                 wdata,
    input  logic [2*DATA_W-1:0]         rline,
    output logic [2*DATA_W-1:0]         st_line,
    output logic [2*(DATA_W/8)-1:0]     st_mask,
    output logic [31:0]                 ld_data
);

    localparam int LINE_W = 2 * DATA_W;
    localparam int MASK_W = 2 * (DATA_W / 8);

    logic [MASK_W-1:0] size_mask;
    logic [31:0]       ld_word;

    // The line is {beat1, beat0}; a crossing access simply spills into the upper beat.
    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = MASK_W'(4'b0001);
            2'b01:   size_mask = MASK_W'(4'b0011);
            default: size_mask = MASK_W'(4'b1111);
        endcase
        st_mask = size_mask << offset;
        st_line = LINE_W'(wdata) << {offset, 3'b000};
        ld_word = 32'(rline >> {offset, 3'b000});
        case (funct3)
            F3_B:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            F3_H:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            F3_BU:   ld_data = {24'b0, ld_word[7:0]};
            F3_HU:   ld_data = {16'b0, ld_word[15:0]};
            F3_W:    ld_data = ld_word;
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: valid/ready core side, request/response data bus with per-beat timeout.
// Define LSU_MISALIGN_EN to split misaligned accesses into bus beats instead of reporting err=01.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);

    lsu_state_t          state_q, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          funct3_q;
    logic                store_q;
    logic [31:0]         wdata_q;
    logic                split_q;
    logic [1:0]          err_q;
    logic [2*DATA_W-1:0] rline_q;
    logic [7:0]          cnt_q;

    logic                acc_illegal, acc_misalign, acc_split;
    logic                cnt_at_limit, timeout_hit;
    logic [ADDR_W-1:0]   base_addr;
    logic [2*DATA_W-1:0] st_line;
    logic [2*B-1:0]      st_mask;
    logic [31:0]         ld_data;

    always_comb begin
        acc_illegal = f3_illegal(req_store, req_funct3);
`ifdef LSU_MISALIGN_EN
        acc_misalign = 1'b0;
        acc_split    = (int'(req_addr[OFF_W-1:0]) + int'(access_size(req_funct3))) > B;
`else
        acc_misalign = misaligned(req_funct3, req_addr[1:0]);
        acc_split    = 1'b0;
`endif
    end

    assign cnt_at_limit = (cnt_q == 8'(TIMEOUT - 1));
    assign base_addr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt   = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) state_nxt = (acc_illegal || acc_misalign) ? S_RESP : S_REQ0;
            S_REQ0, S_REQ1: begin
                if (cnt_at_limit) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_RESP;
                end else if (mem_ready) begin
                    state_nxt = (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (mem_rvalid) begin
                    state_nxt = (state_q == S_WAIT0 && split_q) ? S_REQ1 : S_RESP;
                end else if (cnt_at_limit) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            wdata_q  <= '0;
            split_q  <= 1'b0;
            err_q    <= ERR_OK;
            rline_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_IDLE && req_valid) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                store_q  <= req_store;
                wdata_q  <= req_wdata;
                split_q  <= acc_split;
                err_q    <= acc_illegal ? ERR_ILLEGAL : (acc_misalign ? ERR_MISALIGN : ERR_OK);
                rline_q  <= '0;
            end
            if (state_q == S_WAIT0 && mem_rvalid) rline_q[DATA_W-1:0] <= mem_rdata;
            if (state_q == S_WAIT1 && mem_rvalid) rline_q[2*DATA_W-1:DATA_W] <= mem_rdata;
            if (timeout_hit) err_q <= ERR_TIMEOUT;
            // Beat timer restarts on every entry into a request state.
            if ((state_nxt == S_REQ0 || state_nxt == S_REQ1) && state_nxt != state_q)
                cnt_q <= '0;
            else if (state_q inside {S_REQ0, S_WAIT0, S_REQ1, S_WAIT1})
                cnt_q <= cnt_q + 8'd1;
        end
    end

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .offset  (addr_q[OFF_W-1:0]),
        .funct3  (funct3_q),
        .wdata   (wdata_q),
        .rline   (rline_q),
        .st_line (st_line),
        .st_mask (st_mask),
        .ld_data (ld_data)
    );

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid ? err_q : ERR_OK;
        resp_rdata = (resp_valid && !store_q && err_q == ERR_OK) ? ld_data : 32'b0;
        mem_valid  = (state_q == S_REQ0) || (state_q == S_REQ1);
        mem_we     = mem_valid && store_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        if (state_q == S_REQ0) begin
            mem_addr = base_addr;
            if (store_q) begin
                mem_wdata = st_line[DATA_W-1:0];
                mem_wmask = st_mask[B-1:0];
            end
        end else if (state_q == S_REQ1) begin
            mem_addr = base_addr + ADDR_W'(B);
            if (store_q) begin
                mem_wdata = st_line[2*DATA_W-1:DATA_W];
                mem_wmask = st_mask[2*B-1:B];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (DATA_W=32, TIMEOUT=4): directed cases, then
// randomized accesses compared against a byte-level memory reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 4;
`ifdef LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ref_mem [512];
    logic [7:0]  bus_mem [512];

    int          o_lat, seen_beats;
    logic [1:0]  o_err;
    logic [31:0] o_rdata;
    logic [31:0] obs_addr  [2];
    logic [3:0]  obs_mask  [2];
    logic        obs_we    [2];
    logic [31:0] obs_wdata [2];
    bit          busy_ready_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return {bus_mem[a[8:0] + 9'd3], bus_mem[a[8:0] + 9'd2], bus_mem[a[8:0] + 9'd1], bus_mem[a[8:0]]};
    endfunction

    // Reference: architectural result of the access, computed byte by byte from the rules.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [1:0] err, output int nb,
                         output logic [31:0] rd);
        logic        illegal;
        int          size;
        logic [31:0] v;
        illegal = st ? (f3[2] || f3 == 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size    = 1 << f3[1:0];
        if (illegal)                                err = 2'b11;
        else if (!MIS_EN && (addr % size) != 0)     err = 2'b01;
        else                                        err = 2'b00;
        nb = (err != 2'b00) ? 0 : ((int'(addr % 4) + size > 4) ? 2 : 1);
        v = 32'b0;
        for (int i = 0; i < size && i < 4; i++) v = v | (32'(ref_mem[addr[8:0] + 9'(i)]) << (8 * i));
        case (f3)
            3'd0:    rd = {{24{v[7]}}, v[7:0]};
            3'd1:    rd = {{16{v[15]}}, v[15:0]};
            default: rd = v;
        endcase
        if (err != 2'b00 || st) rd = 32'b0;
        if (st && err == 2'b00)
            for (int i = 0; i < size; i++) ref_mem[addr[8:0] + 9'(i)] = wd[8*i +: 8];
    endtask

    // Issues one request and plays the bus; rdly/vdly are idle cycles before mem_ready/mem_rvalid.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdly, input int vdly, input bit hold);
        int   rc, vc;
        bit   in_wait, done;
        logic [31:0] cur;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        rc = 0; vc = 0; in_wait = 0; done = 0; o_lat = -1; seen_beats = 0; cur = 32'b0;
        o_err = 2'bxx; o_rdata = 32'hx;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            if (resp_valid) begin
                o_lat = k; o_err = resp_err; o_rdata = resp_rdata; done = 1;
            end else begin
                if (req_ready) busy_ready_seen = 1;
                if (in_wait) begin
                    if (vc >= vdly) begin
                        mem_rvalid = 1'b1; mem_rdata = bus_word(cur); in_wait = 0;
                    end else vc++;
                end else if (mem_valid) begin
                    if (rc == 0) begin
                        cur = mem_addr;
                        if (seen_beats < 2) begin
                            obs_addr[seen_beats] = mem_addr; obs_mask[seen_beats] = mem_wmask;
                            obs_we[seen_beats] = mem_we;     obs_wdata[seen_beats] = mem_wdata;
                        end
                        seen_beats++;
                    end
                    if (rc >= rdly) begin
                        mem_ready = 1'b1;
                        if (mem_we)
                            for (int i = 0; i < 4; i++)
                                if (mem_wmask[i]) bus_mem[mem_addr[8:0] + 9'(i)] = mem_wdata[8*i +: 8];
                        in_wait = 1; vc = 0; rc = 0;
                    end else rc++;
                end
            end
        end
        if (!done) check("resp_within_budget", 0, 1);
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdly, input int vdly, input bit hold);
        logic [1:0]  e_err;
        int          e_nb, size, mline;
        logic [31:0] e_rd;
        model(st, f3, addr, wd, e_err, e_nb, e_rd);
        run_op(st, f3, addr, wd, rdly, vdly, hold);
        check("latency", 64'(o_lat), 64'(1 + e_nb * (rdly + vdly + 2)));
        check("resp_err", o_err, e_err);
        check("resp_rdata", o_rdata, e_rd);
        check("beats", 64'(seen_beats), 64'(e_nb));
        size  = 1 << f3[1:0];
        mline = ((1 << size) - 1) << (addr % 4);
        for (int b = 0; b < e_nb && b < 2; b++) begin
            check("mem_addr", obs_addr[b], (addr & ~32'd3) + 32'(4 * b));
            check("mem_wmask", obs_mask[b], st ? 4'((mline >> (4 * b)) & 15) : 4'b0);
            check("mem_we", obs_we[b], st);
        end
    endtask

    initial begin
        logic [1:0]  e_err;
        int          e_nb, diff;
        logic [31:0] e_rd, a, wd;
        logic [2:0]  f3;
        logic        st;
        int          rd, vd;

        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        wd = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            ref_mem[256 + i] = wd[8*i +: 8];
            bus_mem[256 + i] = wd[8*i +: 8];
        end

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
        busy_ready_seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_outputs", {resp_rdata, resp_err, mem_we, mem_addr, mem_wmask}, 0);
        rst = 1'b0;

        // 1: aligned LW, zero-wait bus
        do_op(1'b0, 3'b010, 32'h100, 32'b0, 0, 0, 0);
        check("lw_rdata", o_rdata, 32'hDEADBEEF);
        check("lw_latency", 64'(o_lat), 3);

        // 2: SB lane steering
        do_op(1'b1, 3'b000, 32'h103, 32'h12345678, 0, 0, 0);
        check("sb_addr", obs_addr[0], 32'h100);
        check("sb_mask", obs_mask[0], 4'b1000);
        check("sb_wdata", obs_wdata[0], 32'h78000000);

        // 3: sign vs zero extension
        do_op(1'b1, 3'b010, 32'h100, 32'h00800000, 0, 1, 0);
        do_op(1'b0, 3'b000, 32'h102, 32'b0, 1, 0, 0);
        check("lb_rdata", o_rdata, 32'hFFFFFF80);
        do_op(1'b0, 3'b100, 32'h102, 32'b0, 0, 0, 0);
        check("lbu_rdata", o_rdata, 32'h00000080);

        // 4: misaligned LW across a word boundary
        do_op(1'b1, 3'b010, 32'h100, 32'hAABBCCDD, 0, 0, 0);
        do_op(1'b1, 3'b010, 32'h104, 32'h11223344, 0, 0, 0);
        do_op(1'b0, 3'b010, 32'h102, 32'b0, 0, 0, 0);
`ifdef LSU_MISALIGN_EN
        check("split_rdata", o_rdata, 32'h3344AABB);
        check("split_latency", 64'(o_lat), 5);
        check("split_beat1", obs_addr[1], 32'h104);
`else
        check("mis_err", o_err, 2'b01);
        check("mis_latency", 64'(o_lat), 1);
        check("mis_no_bus", 64'(seen_beats), 0);
`endif

        // 5: timeouts in REQ0 and WAIT0
        run_op(1'b0, 3'b010, 32'h100, 32'b0, 99, 0, 0);
        check("tmo_req_err", o_err, 2'b10);
        check("tmo_req_latency", 64'(o_lat), 64'(1 + TIMEOUT));
        check("tmo_req_rdata", o_rdata, 0);
        @(negedge clk);
        check("tmo_req_ready", req_ready, 1);
        check("tmo_mem_valid", mem_valid, 0);
        run_op(1'b0, 3'b010, 32'h104, 32'b0, 0, 99, 0);
        check("tmo_wait_err", o_err, 2'b10);
        check("tmo_wait_latency", 64'(o_lat), 64'(1 + TIMEOUT));

        // 5b: reset while in WAIT0, then a stray rvalid
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_req", mem_valid, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        check("rst_mid_ready", req_ready, 1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray_rvalid_resp", resp_valid, 0);
        check("stray_rvalid_idle", {req_ready, mem_valid}, 2'b10);
        do_op(1'b0, 3'b010, 32'h104, 32'b0, 0, 0, 0);

        // 6: illegal funct3 and back-to-back requests
        do_op(1'b0, 3'b011, 32'h100, 32'b0, 0, 0, 0);
        check("illegal_ld_err", o_err, 2'b11);
        do_op(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 0, 0, 0);
        check("illegal_st_err", o_err, 2'b11);
        busy_ready_seen = 0;
        do_op(1'b0, 3'b010, 32'h104, 32'b0, 0, 0, 1);
        do_op(1'b0, 3'b001, 32'h106, 32'b0, 1, 0, 1);
        do_op(1'b1, 3'b001, 32'h108, 32'h0000BEEF, 0, 0, 0);
        check("ready_low_while_busy", busy_ready_seen, 0);

        // randomized mix against the reference model
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + 32'($urandom_range(0, 59));
            wd = $urandom;
            rd = int'($urandom_range(0, 1));
            vd = (rd == 0) ? int'($urandom_range(0, 1)) : 0;
            do_op(st, f3, a, wd, rd, vd, 0);
        end

        diff = 0;
        for (int i = 256; i < 320; i++) if (ref_mem[i] !== bus_mem[i]) diff++;
        check("memory_image", 64'(diff), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
